// File: rtl/sram_axi_bridge.sv
// Bridges the instruction/data SRAM-like request ports onto one AXI3 master.
// At most one read and one write are in flight; the data port keeps read-after-write order.
module sram_axi_bridge #(
    parameter logic [3:0] ARID_INST = 4'd0,
    parameter logic [3:0] ARID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    // Every channel is valid/ready: a transfer happens in the cycle both are high.
    typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;
    logic [31:0] r_addr, w_addr, w_data;
    logic [1:0]  r_size, w_size;
    logic [3:0]  r_id, w_strb;
    logic        aw_done, w_done;
    logic        inst_rd_acc, data_rd_acc, data_wr_acc;
    logic        r_fire, r_to_inst, w_data_ok;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rresp, rlast, bid, bresp};

    // Outputs are gated by resetn so a reset cycle never completes a handshake.
    always_comb begin
        r_next      = r_state;
        inst_rd_acc = 1'b0;
        data_rd_acc = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        if (resetn) begin
            case (r_state)
                R_IDLE: begin
                    if (data_sram_req && !data_sram_wr && w_state == W_IDLE) begin
                        data_rd_acc = 1'b1;
                        r_next      = R_AR;
                    end else if (inst_sram_req) begin
                        inst_rd_acc = 1'b1;
                        r_next      = R_AR;
                    end
                end
                R_AR: begin
                    arvalid = 1'b1;
                    if (arready) r_next = R_WAIT;
                end
                R_WAIT: begin
                    rready = 1'b1;
                    if (rvalid) r_next = R_IDLE;
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    always_comb begin
        w_next      = w_state;
        data_wr_acc = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        w_data_ok   = 1'b0;
        if (resetn) begin
            case (w_state)
                W_IDLE: begin
                    if (data_sram_req && data_sram_wr &&
                        (r_state == R_IDLE || r_id == ARID_INST)) begin
                        data_wr_acc = 1'b1;
                        w_next      = W_SEND;
                    end
                end
                W_SEND: begin
                    awvalid = !aw_done;
                    wvalid  = !w_done;
                    if ((aw_done || awready) && (w_done || wready)) w_next = W_RESP;
                end
                W_RESP: begin
                    bready = 1'b1;
                    if (bvalid) begin
                        w_data_ok = 1'b1;
                        w_next    = W_IDLE;
                    end
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    // An unrecognised rid still completes to whichever port issued the read.
    assign r_fire    = rready && rvalid;
    assign r_to_inst = (rid == ARID_INST) ? 1'b1 :
                       (rid == ARID_DATA) ? 1'b0 : (r_id == ARID_INST);

    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
    assign inst_sram_data_ok = r_fire && r_to_inst;
    assign data_sram_data_ok = (r_fire && !r_to_inst) || w_data_ok;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = r_id;
    assign araddr  = r_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, r_size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = 4'd1;
    assign awaddr  = w_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, w_size};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd1;
    assign wdata   = w_data;
    assign wstrb   = w_strb;
    assign wlast   = 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            r_addr  <= '0;
            r_size  <= '0;
            r_id    <= '0;
            w_addr  <= '0;
            w_data  <= '0;
            w_size  <= '0;
            w_strb  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
            if (data_rd_acc) begin
                r_addr <= data_sram_addr;
                r_size <= data_sram_size;
                r_id   <= ARID_DATA;
            end else if (inst_rd_acc) begin
                r_addr <= inst_sram_addr;
                r_size <= inst_sram_size;
                r_id   <= ARID_INST;
            end
            if (data_wr_acc) begin
                w_addr <= data_sram_addr;
                w_data <= data_sram_wdata;
                w_size <= data_sram_size;
                w_strb <= data_sram_wstrb;
            end
            // Per-channel completion flags live only while W_SEND persists.
            if (w_state == W_SEND && w_next == W_SEND) begin
                aw_done <= aw_done || (awvalid && awready);
                w_done  <= w_done  || (wvalid && wready);
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end
endmodule
